// File: rtl/keyled_memtest_master_if.sv
// keyled_memtest_master_if
//   Avalon-MM bus between the memory-test master and the keyled data RAM.
//   master modport: request side (address/byteenable/chipselect/write/read/
//                   writedata out; readdata/waitrequest in)
//   slave  modport: RAM side (mirror of master)
interface keyled_memtest_master_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic                avm_read;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;

    modport master (
        output avm_address, avm_byteenable, avm_chipselect,
               avm_write, avm_read, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_chipselect,
               avm_write, avm_read, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/keyled_memtest_master.sv
// keyled_memtest_master
//   Avalon-MM memory test master for the keyled data RAM. On start it writes a
//   pattern over [base, base+N) (wrapping at DEPTH), reads the range back with
//   pipelined reads and reports pass / saturating error count / first bad addr.
// Ports:
//   clk, reset_n (async active-low)
//   start, base_addr, num_words, seed         : test request (sampled in IDLE)
//   busy, done, pass, err_count, first_err_addr: status
//   avm (master modport)                       : Avalon-MM bus to the RAM
// Build option:
//   KEYLED_MEMTEST_ADDR_PATTERN_EN defined -> pattern is seed + word index
//   (catches address aliasing); undefined -> every word gets seed.
module keyled_memtest_master #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 10240,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      num_words,
    input  logic [DATA_W-1:0]    seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          err_count,
    output logic [ADDR_W-1:0]    first_err_addr,
    keyled_memtest_master_if.master avm
);
    localparam int              LAT     = READ_LATENCY;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [LAT-1:0]  OLDEST  = LAT'(1) << (LAT-1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic                busy_q, done_q, pass_q, wr_q, rd_q;
    logic [15:0]         err_q, err_d;
    logic [ADDR_W-1:0]   ferr_q, ferr_d;
    logic [ADDR_W-1:0]   base_q, addr_q, addr_nxt;
    logic [ADDR_W:0]     n_q, rem_q, n_clamp;
    logic [DATA_W-1:0]   seed_q, wdata_q, exp_q;
    logic [LAT-1:0]      vld_pipe_q;
    logic [ADDR_W-1:0]   addr_pipe_q [LAT];
    logic [DATA_W-1:0]   exp_pipe_q  [LAT];
    logic                wr_acc, rd_acc, younger;

    // One conditional subtract is enough: every input is < 2*DEPTH.
    function automatic logic [ADDR_W-1:0] wrap(input logic [ADDR_W:0] a);
        return (a >= DEPTH_W) ? ADDR_W'(a - DEPTH_W) : ADDR_W'(a);
    endfunction

    always_comb begin
        wr_acc   = wr_q & ~avm.avm_waitrequest;
        rd_acc   = rd_q & ~avm.avm_waitrequest;
        addr_nxt = wrap({1'b0, addr_q} + (ADDR_W+1)'(1));
        n_clamp  = (num_words > DEPTH_W) ? DEPTH_W : num_words;
        // Entries other than the one maturing this cycle still outstanding.
        younger  = |(vld_pipe_q & ~OLDEST);
        err_d    = err_q;
        ferr_d   = ferr_q;
        if (vld_pipe_q[LAT-1] && (avm.avm_readdata != exp_pipe_q[LAT-1])) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    ferr_d = addr_pipe_q[LAT-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ferr_q     <= '0;
            base_q     <= '0;
            n_q        <= '0;
            rem_q      <= '0;
            seed_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            exp_q      <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            vld_pipe_q <= '0;
            for (int j = 0; j < LAT; j++) begin
                addr_pipe_q[j] <= '0;
                exp_pipe_q[j]  <= '0;
            end
        end else begin
            err_q  <= err_d;
            ferr_q <= ferr_d;

            // Read-return pipe: stage LAT-1 lines up with avm_readdata.
            vld_pipe_q[0]  <= rd_acc;
            addr_pipe_q[0] <= addr_q;
            exp_pipe_q[0]  <= exp_q;
            for (int j = 1; j < LAT; j++) begin
                vld_pipe_q[j]  <= vld_pipe_q[j-1];
                addr_pipe_q[j] <= addr_pipe_q[j-1];
                exp_pipe_q[j]  <= exp_pipe_q[j-1];
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= wrap({1'b0, base_addr});
                        n_q     <= n_clamp;
                        rem_q   <= n_clamp;
                        seed_q  <= seed;
                        err_q   <= '0;
                        ferr_q  <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!wr_q) begin
                        // Setup cycle after start: issue the first write, or
                        // finish at once for an empty range.
                        if (rem_q == '0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            wr_q    <= 1'b1;
                            addr_q  <= base_q;
                            wdata_q <= seed_q;
                        end
                    end else if (wr_acc) begin
                        if (rem_q == (ADDR_W+1)'(1)) begin
                            // Last write accepted: first read goes out next cycle.
                            wr_q    <= 1'b0;
                            wdata_q <= '0;
                            rd_q    <= 1'b1;
                            addr_q  <= base_q;
                            exp_q   <= seed_q;
                            rem_q   <= n_q;
                            state_q <= S_READ;
                        end else begin
                            rem_q   <= rem_q - (ADDR_W+1)'(1);
                            addr_q  <= addr_nxt;
`ifdef KEYLED_MEMTEST_ADDR_PATTERN_EN
                            wdata_q <= wdata_q + DATA_W'(1);
`endif
                        end
                    end
                end
                S_READ: begin
                    if (rd_acc) begin
                        if (rem_q == (ADDR_W+1)'(1)) begin
                            rd_q    <= 1'b0;
                            addr_q  <= '0;
                            state_q <= S_DRAIN;
                        end else begin
                            rem_q  <= rem_q - (ADDR_W+1)'(1);
                            addr_q <= addr_nxt;
`ifdef KEYLED_MEMTEST_ADDR_PATTERN_EN
                            exp_q  <= exp_q + DATA_W'(1);
`endif
                        end
                    end
                end
                S_DRAIN: begin
                    // Leave when only the maturing entry is left; its compare
                    // lands in err_d this cycle so pass sees it.
                    if (!younger) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 16'd0);
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign pass               = pass_q;
    assign err_count          = err_q;
    assign first_err_addr     = ferr_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_write      = wr_q;
    assign avm.avm_read       = rd_q;
    assign avm.avm_chipselect = wr_q | rd_q;
    assign avm.avm_byteenable = {(DATA_W/8){wr_q | rd_q}};
    assign avm.avm_writedata  = wdata_q;
endmodule

// File: tb/tb_keyled_memtest_master.sv
// tb_keyled_memtest_master
//   Directed + randomized bench for keyled_memtest_master with a behavioural
//   RAM slave (1-cycle read latency, optional random waitrequest, per-address
//   readback corruption) and an expectation model computed from the range.
module tb_keyled_memtest_master;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 10240;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic [DATA_W-1:0] seed;
    logic              busy, done, pass;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;

    keyled_memtest_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    keyled_memtest_master dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_words(num_words), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .avm(ifc.master)
    );

    always #5 clk = ~clk;

    // ---------------- RAM slave model ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    bit                corrupt [DEPTH];
    logic [DATA_W-1:0] rdata = '0;
    logic              wait_r = 1'b0;
    bit                stall_en = 1'b0;
    int                wr_cnt, rd_cnt, cs_cnt, oob, both, unstable;
    int                wr_log[$];
    bit                stalled_prev = 1'b0;
    logic [ADDR_W+DATA_W+1:0] prev_req;

    assign ifc.avm_readdata    = rdata;
    assign ifc.avm_waitrequest = wait_r;

    always @(posedge clk) begin
        if (reset_n) begin
            if (ifc.avm_chipselect) cs_cnt++;
            if (ifc.avm_chipselect && int'(ifc.avm_address) >= DEPTH) oob++;
            if (ifc.avm_read && ifc.avm_write) both++;
            if (stalled_prev &&
                prev_req != {ifc.avm_address, ifc.avm_writedata, ifc.avm_read, ifc.avm_write})
                unstable++;
            if (ifc.avm_chipselect && !wait_r && int'(ifc.avm_address) < DEPTH) begin
                if (ifc.avm_write) begin
                    mem[ifc.avm_address] <= ifc.avm_writedata;
                    wr_cnt++;
                    wr_log.push_back(int'(ifc.avm_address));
                end
                if (ifc.avm_read) begin
                    rdata <= mem[ifc.avm_address] ^ (corrupt[ifc.avm_address] ? 32'h1 : 32'h0);
                    rd_cnt++;
                end
            end
            stalled_prev = ifc.avm_chipselect && wait_r;
            prev_req     = {ifc.avm_address, ifc.avm_writedata, ifc.avm_read, ifc.avm_write};
        end else begin
            stalled_prev = 1'b0;
        end
        wait_r <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // ---------------- checking ----------------
    int total = 0, pass_cnt = 0, fail_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [DATA_W-1:0] sd, input int i);
`ifdef KEYLED_MEMTEST_ADDR_PATTERN_EN
        return sd + DATA_W'(i);
`else
        return sd + DATA_W'(0 * i);
`endif
    endfunction

    task automatic clear_corrupt();
        for (int k = 0; k < DEPTH; k++) corrupt[k] = 1'b0;
    endtask

    task automatic run(input int b, input int n, input logic [31:0] sd,
                       input bit stall, input bit poke, input string tag);
        int eff_n, bb, exp_err, exp_first, a, cyc, last;
        eff_n = (n > DEPTH) ? DEPTH : n;
        bb    = b % DEPTH;
        exp_err = 0; exp_first = 0;
        for (int i = 0; i < eff_n; i++) begin
            a = (bb + i) % DEPTH;
            if (corrupt[a]) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        end
        stall_en = stall;
        wr_cnt = 0; rd_cnt = 0; cs_cnt = 0; oob = 0; both = 0; unstable = 0;
        wr_log.delete();
        base_addr = ADDR_W'(b); num_words = (ADDR_W+1)'(n); seed = sd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (!done && cyc < 30000) begin
            if (poke && cyc == 5) begin
                start = 1'b1; base_addr = ADDR_W'($urandom); num_words = 15'd7;
            end else start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " done"}, 64'(done), 64'd1);
        if (!stall) chk({tag, " latency"}, 64'(cyc), 64'((eff_n == 0) ? 2 : 2 * eff_n + 3));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " pass"}, 64'(pass), 64'(exp_err == 0));
        chk({tag, " err_count"}, 64'(err_count), 64'(exp_err));
        chk({tag, " first_err"}, 64'(first_err_addr), 64'(exp_first));
        chk({tag, " writes"}, 64'(wr_cnt), 64'(eff_n));
        chk({tag, " reads"}, 64'(rd_cnt), 64'(eff_n));
        chk({tag, " proto"}, {oob[15:0], both[15:0], unstable[15:0]}, 64'd0);
        if (eff_n == 0) chk({tag, " no bus"}, 64'(cs_cnt), 64'd0);
        else begin
            last = (bb + eff_n - 1) % DEPTH;
            chk({tag, " mem first"}, 64'(mem[bb]), 64'(pat(sd, 0)));
            chk({tag, " mem last"}, 64'(mem[last]), 64'(pat(sd, eff_n - 1)));
        end
        stall_en = 1'b0;
        @(posedge clk); #1;
        chk({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int b, n, nc, k, dseen;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; seed = '0;
        clear_corrupt();
        repeat (3) @(posedge clk);
        #1;
        chk("reset status", {busy, done, pass, err_count, first_err_addr}, 64'd0);
        chk("reset bus", {ifc.avm_address, ifc.avm_byteenable, ifc.avm_chipselect,
                          ifc.avm_write, ifc.avm_read, ifc.avm_writedata}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run(0, 16, 32'hA5A5_0000, 1'b0, 1'b0, "clean16");
        corrupt[5] = 1'b1;
        run(0, 16, 32'hA5A5_0000, 1'b0, 1'b0, "bad5");
        corrupt[9] = 1'b1;
        run(0, 16, 32'h1234_5678, 1'b0, 1'b0, "bad5_9");
        clear_corrupt();

        run(10238, 4, 32'hDEAD_BEEF, 1'b0, 1'b0, "wrap");
        chk("wrap a0", 64'(wr_log[0]), 64'd10238);
        chk("wrap a1", 64'(wr_log[1]), 64'd10239);
        chk("wrap a2", 64'(wr_log[2]), 64'd0);
        chk("wrap a3", 64'(wr_log[3]), 64'd1);

        run(300, 64, 32'hC0DE_0001, 1'b1, 1'b1, "stall");
        run(77, 0, 32'h0, 1'b0, 1'b0, "n0");
        run(0, 20000, 32'h5A5A_5A5A, 1'b0, 1'b0, "clamp");

        // Reset while the 8th read (i=7) is on the bus.
        base_addr = 14'd100; num_words = 15'd16; seed = 32'h0F0F_0F0F; start = 1'b1;
        rd_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (rd_cnt < 7 && k < 200) begin @(posedge clk); #1; k++; end
        chk("mid reads", 64'(rd_cnt), 64'd7);
        reset_n = 1'b0;
        #1;
        chk("midrst status", {busy, done, pass, err_count, first_err_addr}, 64'd0);
        chk("midrst bus", {ifc.avm_address, ifc.avm_byteenable, ifc.avm_chipselect,
                           ifc.avm_write, ifc.avm_read, ifc.avm_writedata}, 64'd0);
        dseen = 0;
        repeat (3) begin @(posedge clk); #1; if (done) dseen++; end
        reset_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done || busy) dseen++; end
        chk("midrst no done", 64'(dseen), 64'd0);
        run(100, 16, 32'h0F0F_0F0F, 1'b0, 1'b0, "after rst");

        // Randomized ranges, stalls and corruptions.
        for (int t = 0; t < 6; t++) begin
            b  = int'($urandom_range(0, 16383));
            n  = int'($urandom_range(0, 40));
            clear_corrupt();
            nc = (n == 0) ? 0 : int'($urandom_range(0, 2));
            for (int c = 0; c < nc; c++)
                corrupt[(b % DEPTH + int'($urandom_range(0, n - 1))) % DEPTH] = 1'b1;
            run(b, n, $urandom, 1'($urandom_range(0, 1)), n >= 3, $sformatf("rand%0d", t));
        end
        clear_corrupt();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
